// File: rtl/map_pkg.sv
// map_pkg: tile codes, map dimensions, arbiter states and the map range check shared by the map and its access arbiter
package map_pkg;
  localparam logic [1:0] TILE_EMPTY = 2'd0;
  localparam logic [1:0] TILE_BRICK = 2'd1;
  localparam logic [1:0] TILE_STEEL = 2'd2;
  localparam int MAP_W = 25;
  localparam int MAP_H = 18;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} arb_state_t;
  function automatic logic in_map(input logic [4:0] x, input logic [4:0] y);
    return (int'(x) < MAP_W) && (int'(y) < MAP_H);
  endfunction
endpackage

// File: rtl/map_access_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick starting at ptr; req/ptr in, one-hot grant and its index out
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx
);
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N_REQ]) begin
        grant = '0;
        grant[(int'(ptr) + i) % N_REQ] = 1'b1;
        idx = IW'((int'(ptr) + i) % N_REQ);
      end
    end
  end
endmodule

// File: rtl/map_access_arbiter.sv
// map_access_arbiter: round-robin tile read / brick-destroy access to the map; clk/rstn, req_* in, req_ready/rsp_* out, map_rd_*/map_wr_* map ports, bricks_destroyed count, busy
module map_access_arbiter
  import map_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [5*N_REQ-1:0] req_x,
  input  logic [5*N_REQ-1:0] req_y,
  input  logic [N_REQ-1:0]   req_destroy,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [1:0]         rsp_tile,
  output logic [4:0]         map_rd_x,
  output logic [4:0]         map_rd_y,
  input  logic [1:0]         map_rd_tile,
  output logic               map_wr_en,
  output logic [4:0]         map_wr_x,
  output logic [4:0]         map_wr_y,
  output logic [1:0]         map_wr_tile,
  output logic [7:0]         bricks_destroyed,
  output logic               busy
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  arb_state_t state, state_nx;
  logic [IW-1:0] ptr, g_idx, win_idx;
  logic [N_REQ-1:0] win;
  logic [4:0] lat_x, lat_y;
  logic lat_d;
  logic [1:0] tile_q;
  logic [7:0] cnt;
  logic grant_fire;
  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req  (req_valid),
    .ptr  (ptr),
    .grant(win),
    .idx  (win_idx)
  );
  always_ff @(posedge clk) state <= !rstn ? S_IDLE : state_nx;
  always_comb begin
    state_nx = state == S_IDLE  ? (|req_valid ? S_ISSUE : S_IDLE) :
               state == S_ISSUE ? S_WAIT :
               state == S_WAIT  ? S_RESP : S_IDLE;
  end
  always_comb begin
    grant_fire = rstn && state == S_IDLE && |req_valid;
    req_ready = grant_fire ? win : '0;
    rsp_valid = (rstn && state == S_RESP) ? N_REQ'(1) << g_idx : '0;
    map_wr_en = rstn && state == S_RESP && lat_d && tile_q == TILE_BRICK;
    busy = state != S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= '0;
      g_idx <= '0;
      lat_x <= '0;
      lat_y <= '0;
      lat_d <= 1'b0;
      tile_q <= TILE_EMPTY;
      cnt <= '0;
    end else begin
      if (grant_fire) begin
        ptr <= win_idx == IW'(N_REQ - 1) ? '0 : win_idx + 1'b1;
        g_idx <= win_idx;
        lat_x <= req_x[5*int'(win_idx) +: 5];
        lat_y <= req_y[5*int'(win_idx) +: 5];
        lat_d <= req_destroy[win_idx];
      end
      if (state == S_WAIT) tile_q <= in_map(lat_x, lat_y) ? map_rd_tile : TILE_STEEL;
      if (map_wr_en && cnt != 8'hFF) cnt <= cnt + 8'd1;
    end
  end
  assign rsp_tile = tile_q;
  assign map_rd_x = lat_x;
  assign map_rd_y = lat_y;
  assign map_wr_x = lat_x;
  assign map_wr_y = lat_y;
  assign map_wr_tile = TILE_EMPTY;
  assign bricks_destroyed = cnt;
endmodule

// File: tb/tb_map_access_arbiter.sv
// tb_map_access_arbiter: directed and randomized transactions against a map memory and a transaction-level reference model
module tb_map_access_arbiter;
  import map_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid = '0, req_destroy = '0, req_ready, rsp_valid;
  logic [5*N-1:0] req_x, req_y;
  logic [1:0] rsp_tile, map_rd_tile, map_wr_tile;
  logic [4:0] map_rd_x, map_rd_y, map_wr_x, map_wr_y;
  logic map_wr_en, busy;
  logic [7:0] bricks_destroyed;
  logic [4:0] rx [N];
  logic [4:0] ry [N];
  genvar i;
  for (i = 0; i < N; i++) begin : g_pack
    assign req_x[5*i +: 5] = rx[i];
    assign req_y[5*i +: 5] = ry[i];
  end
  map_access_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_destroy(req_destroy), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_tile(rsp_tile),
    .map_rd_x(map_rd_x), .map_rd_y(map_rd_y), .map_rd_tile(map_rd_tile), .map_wr_en(map_wr_en),
    .map_wr_x(map_wr_x), .map_wr_y(map_wr_y), .map_wr_tile(map_wr_tile),
    .bricks_destroyed(bricks_destroyed), .busy(busy)
  );
  logic [1:0] map_mem [MAP_W*MAP_H];
  logic [1:0] ref_mem [MAP_W*MAP_H];
  logic load = 1'b0;
  always @(posedge clk) begin
    map_rd_tile <= (map_rd_x < 25 && map_rd_y < 18) ? map_mem[int'(map_rd_y)*25 + int'(map_rd_x)] : 2'd0;
    if (load) map_mem <= ref_mem;
    else if (map_wr_en && map_wr_x < 25 && map_wr_y < 18) map_mem[int'(map_wr_y)*25 + int'(map_wr_x)] <= map_wr_tile;
  end
  int vectors = 0;
  int miscompares = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load_map();
    req_valid = '0;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask
  task automatic zero_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_rsp"}, rsp_valid, 0);
    chk({tag, "_tile"}, rsp_tile, 0);
    chk({tag, "_rdx"}, map_rd_x, 0);
    chk({tag, "_rdy"}, map_rd_y, 0);
    chk({tag, "_wren"}, map_wr_en, 0);
    chk({tag, "_wrx"}, map_wr_x, 0);
    chk({tag, "_wry"}, map_wr_y, 0);
    chk({tag, "_wrt"}, map_wr_tile, 0);
    chk({tag, "_cnt"}, bricks_destroyed, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask
  task automatic txn(input logic [N-1:0] v, input bit scramble);
    int g;
    logic [4:0] gx, gy;
    logic gd;
    logic [1:0] et;
    bit ew;
    req_valid = v;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    gx = rx[g];
    gy = ry[g];
    gd = req_destroy[g];
    et = (gx < 25 && gy < 18) ? ref_mem[int'(gy)*25 + int'(gx)] : TILE_STEEL;
    ew = gd && et == TILE_BRICK;
    chk("grant", req_ready, 1 << g);
    chk("idle_busy", busy, 0);
    chk("idle_rsp", rsp_valid, 0);
    tick();
    if (scramble) begin
      req_valid = 4'($urandom);
      req_destroy = 4'($urandom);
      for (int k = 0; k < N; k++) begin
        rx[k] = 5'($urandom);
        ry[k] = 5'($urandom);
      end
    end
    chk("issue_ready", req_ready, 0);
    chk("issue_busy", busy, 1);
    chk("rd_x", map_rd_x, gx);
    chk("rd_y", map_rd_y, gy);
    tick();
    chk("wait_ready", req_ready, 0);
    chk("wait_rsp", rsp_valid, 0);
    chk("wait_wr", map_wr_en, 0);
    tick();
    chk("rsp_valid", rsp_valid, 1 << g);
    chk("rsp_tile", rsp_tile, et);
    chk("wr_en", map_wr_en, ew);
    chk("rsp_ready", req_ready, 0);
    if (ew) begin
      chk("wr_x", map_wr_x, gx);
      chk("wr_y", map_wr_y, gy);
      chk("wr_tile", map_wr_tile, TILE_EMPTY);
      ref_mem[int'(gy)*25 + int'(gx)] = TILE_EMPTY;
      if (m_cnt < 255) m_cnt++;
    end
    m_ptr = (g + 1) % N;
    tick();
    chk("cnt", bricks_destroyed, m_cnt);
    chk("done_busy", busy, 0);
    chk("done_rsp", rsp_valid, 0);
    chk("done_wr", map_wr_en, 0);
    chk("hold_tile", rsp_tile, et);
  endtask
  initial begin
    for (int k = 0; k < N; k++) begin
      rx[k] = '0;
      ry[k] = '0;
    end
    for (int k = 0; k < MAP_W*MAP_H; k++) ref_mem[k] = 2'($urandom_range(0, 2));
    ref_mem[3*25 + 4] = TILE_BRICK;
    ref_mem[8*25 + 12] = TILE_STEEL;
    rstn = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    zero_outputs("reset");
    rstn = 1'b1;
    tick();
    zero_outputs("post_reset");
    rx[0] = 5'd4; ry[0] = 5'd3; req_destroy = 4'b0000;
    txn(4'b0001, 1'b0);
    rx[1] = 5'd4; ry[1] = 5'd3; req_destroy = 4'b0010;
    txn(4'b0010, 1'b0);
    chk("first_brick", bricks_destroyed, 1);
    rx[0] = 5'd4; ry[0] = 5'd3; req_destroy = 4'b0000;
    txn(4'b0001, 1'b0);
    rx[2] = 5'd12; ry[2] = 5'd8; req_destroy = 4'b0100;
    txn(4'b0100, 1'b0);
    rx[3] = 5'd30; ry[3] = 5'd5; req_destroy = 4'b1000;
    txn(4'b1000, 1'b0);
    chk("cnt_after_steel", bricks_destroyed, 1);
    for (int k = 0; k < N; k++) begin
      rx[k] = 5'($urandom_range(0, 24));
      ry[k] = 5'($urandom_range(0, 17));
    end
    req_destroy = 4'b0000;
    for (int k = 0; k < 5; k++) txn(4'b1111, 1'b0);
    rx[1] = 5'd7; ry[1] = 5'd2; req_destroy = 4'b0010;
    ref_mem[2*25 + 7] = TILE_BRICK;
    load_map();
    req_valid = 4'b0010;
    #1;
    chk("abort_grant", req_ready, 4'b0010);
    tick();
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    req_valid = '0;
    m_ptr = 0;
    m_cnt = 0;
    zero_outputs("abort");
    tick();
    chk("abort_rsp", rsp_valid, 0);
    chk("abort_wr", map_wr_en, 0);
    tick();
    chk("abort_rsp2", rsp_valid, 0);
    chk("abort_wr2", map_wr_en, 0);
    txn(4'b1111, 1'b0);
    rx[1] = 5'd7; ry[1] = 5'd2; req_destroy = 4'b0000;
    txn(4'b0010, 1'b0);
    for (int n = 0; n < 150; n++) begin
      for (int k = 0; k < N; k++) begin
        rx[k] = $urandom_range(0, 9) == 0 ? 5'($urandom_range(25, 31)) : 5'($urandom_range(0, 24));
        ry[k] = $urandom_range(0, 9) == 0 ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      end
      req_destroy = 4'($urandom);
      txn(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
    end
    req_valid = '0;
    tick();
    for (int k = 0; k < MAP_W*MAP_H; k++) ref_mem[k] = TILE_BRICK;
    load_map();
    for (int p = 0; p < 300; p++) begin
      int r;
      r = $urandom_range(0, N - 1);
      rx[r] = 5'(p % 25);
      ry[r] = 5'(p / 25);
      req_destroy = 4'(1 << r);
      txn(4'(1 << r), 1'b0);
    end
    chk("saturated", bricks_destroyed, 255);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
